// File: rtl/ram_sync_dp_if.sv
// Bus bundle for ram_sync_dp: one write port, one read port, and status.
// The master drives the strobes; the RAM drives the read data and status.
interface ram_sync_dp_if #(
    parameter int unsigned MEM_ADDR_WIDTH = 8,
    parameter int unsigned MEM_DATA_WIDTH = 8
);
    logic                      wr_en;
    logic [MEM_ADDR_WIDTH-1:0] wr_address;
    logic [MEM_DATA_WIDTH-1:0] wr_data;
    logic                      rd_en;
    logic [MEM_ADDR_WIDTH-1:0] rd_address;
    logic [MEM_DATA_WIDTH-1:0] rd_data;
    logic                      rd_valid;
    logic                      ready;

    modport master (
        output wr_en, wr_address, wr_data, rd_en, rd_address,
        input  rd_data, rd_valid, ready
    );

    modport slave (
        input  wr_en, wr_address, wr_data, rd_en, rd_address,
        output rd_data, rd_valid, ready
    );
endinterface

// File: rtl/ram_sync_dp.sv
// Simple dual-port synchronous RAM with a post-reset clear engine,
// a selectable read-during-write policy and an optional output register.
module ram_sync_dp #(
    parameter int unsigned MEM_ADDR_WIDTH = 8,
    parameter int unsigned MEM_DATA_WIDTH = 8,
    parameter bit          OUT_REG        = 1'b0,
    parameter bit          RDW_MODE       = 1'b0,
    parameter logic [MEM_DATA_WIDTH-1:0] CLEAR_VALUE = '0
) (
    input logic          clock,
    input logic          reset,
    ram_sync_dp_if.slave bus
);
    localparam int unsigned MEM_DEPTH = 2 ** MEM_ADDR_WIDTH;
    localparam logic [MEM_ADDR_WIDTH-1:0] LAST_ADDR =
        MEM_ADDR_WIDTH'(MEM_DEPTH - 1);

    typedef enum logic {
        ST_CLEAR,
        ST_READY
    } state_e;

    state_e                    state_q, state_d;
    logic [MEM_ADDR_WIDTH-1:0] clear_addr_q, clear_addr_d;
    logic [MEM_DATA_WIDTH-1:0] mem_q [MEM_DEPTH];

    logic                      mem_we;
    logic [MEM_ADDR_WIDTH-1:0] mem_waddr;
    logic [MEM_DATA_WIDTH-1:0] mem_wdata;
    logic                      wr_go;
    logic                      rd_go;
    logic                      fwd;

    logic                      rd1_valid_q, rd1_valid_d;
    logic [MEM_DATA_WIDTH-1:0] rd1_data_q, rd1_data_d;
    logic                      rd2_valid_q, rd2_valid_d;
    logic [MEM_DATA_WIDTH-1:0] rd2_data_q, rd2_data_d;

    always_comb begin
        state_d      = state_q;
        clear_addr_d = clear_addr_q;
        wr_go        = (state_q == ST_READY) && bus.wr_en;
        rd_go        = (state_q == ST_READY) && bus.rd_en;
        mem_we       = 1'b0;
        mem_waddr    = bus.wr_address;
        mem_wdata    = bus.wr_data;
        unique case (state_q)
            ST_CLEAR: begin
                mem_we       = 1'b1;
                mem_waddr    = clear_addr_q;
                mem_wdata    = CLEAR_VALUE;
                clear_addr_d = clear_addr_q + 1'b1;
                if (clear_addr_q == LAST_ADDR) begin
                    state_d = ST_READY;
                end
            end
            ST_READY: begin
                mem_we = wr_go;
            end
        endcase

        // Same-address forwarding only applies in new-data mode
        fwd = RDW_MODE && wr_go && (bus.wr_address == bus.rd_address);

        rd1_valid_d = rd_go;
        rd1_data_d  = rd1_data_q;
        if (rd_go) begin
            rd1_data_d = fwd ? bus.wr_data : mem_q[bus.rd_address];
        end

        rd2_valid_d = rd1_valid_q;
        rd2_data_d  = rd1_valid_q ? rd1_data_q : rd2_data_q;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= ST_CLEAR;
            clear_addr_q <= '0;
            rd1_valid_q  <= 1'b0;
            rd1_data_q   <= '0;
            rd2_valid_q  <= 1'b0;
            rd2_data_q   <= '0;
        end else begin
            state_q      <= state_d;
            clear_addr_q <= clear_addr_d;
            rd1_valid_q  <= rd1_valid_d;
            rd1_data_q   <= rd1_data_d;
            rd2_valid_q  <= rd2_valid_d;
            rd2_data_q   <= rd2_data_d;
        end
    end

    // Storage has no reset so it maps onto block RAM
    always_ff @(posedge clock) begin
        if (mem_we && !reset) begin
            mem_q[mem_waddr] <= mem_wdata;
        end
    end

    assign bus.ready    = (state_q == ST_READY);
    assign bus.rd_valid = OUT_REG ? rd2_valid_q : rd1_valid_q;
    assign bus.rd_data  = OUT_REG ? rd2_data_q : rd1_data_q;
endmodule

// File: doc/ram_sync_dp.md
# ram_sync_dp

Parametrised simple-dual-port synchronous RAM: one dedicated write port and one dedicated read port that operate in the same cycle. It is the next generation of the single-port computer memory. It adds a selectable read-during-write policy, an optional output pipeline register, a read-valid strobe, and a reset-time clear engine that fills every location with a known value. It sits between the bus/control unit and the program/data store.

## Interface
- MEM_ADDR_WIDTH, 8, address width; depth MEM_DEPTH = 2**MEM_ADDR_WIDTH
- MEM_DATA_WIDTH, 8, word width
- OUT_REG, 0, 1 = extra output register stage (read latency 2); 0 = latency 1
- RDW_MODE, 0, same-address read/write in the same cycle: 0 = old data, 1 = new data (forwarded)
- CLEAR_VALUE, 0, MEM_DATA_WIDTH-bit value written to every location after reset
- clock  input  1  sole clock; all logic on rising edge
- reset  input  1  synchronous, active-high; restarts the clear engine
- wr_en  input  1  write strobe
- wr_address  input  MEM_ADDR_WIDTH  write address
- wr_data  input  MEM_DATA_WIDTH  write data
- rd_en  input  1  read strobe
- rd_address  input  MEM_ADDR_WIDTH  read address
- rd_data  output  MEM_DATA_WIDTH  read data; holds its last value when no read completes
- rd_valid  output  1  one-cycle pulse marking rd_data as a completed read
- ready  output  1  high once the clear has finished; user strobes accepted only while high

## Operation
- **States.** CLEAR, then READY. Reset forces CLEAR, clear_addr = 0, ready = 0, rd_valid = 0, rd_data = 0, and clears the OUT_REG stage and its valid bit.
- **CLEAR state.**
  - Every cycle with reset low, write CLEAR_VALUE to memory[clear_addr].
  - On the cycle that writes address MEM_DEPTH-1, move to READY and set ready = 1.
  - Detect the end of the clear by comparing against MEM_DEPTH-1, not by relying on counter wrap. clear_addr is MEM_ADDR_WIDTH bits wide.
- **Strobes while not ready.** wr_en and rd_en are ignored: no memory write from the user port, and no rd_valid.
- **READY state.**
  - wr_en = 1: memory[wr_address] <= wr_data.
  - rd_en = 1: launch a read of rd_address.
  - Both strobes may be active in the same cycle, to any addresses.
- **Read-during-write**, when rd_en and wr_en are both 1 and rd_address == wr_address:
  - RDW_MODE = 0 returns the pre-write contents.
  - RDW_MODE = 1 returns wr_data.
  - With different addresses the two ports are fully independent.
- **Reset mid-operation.**
  - Reset during CLEAR restarts the clear from address 0.
  - Reset during READY drops ready and re-clears the whole array.
  - Any in-flight read is discarded: no rd_valid.
- **Back-to-back reads.** Fully pipelined: one read accepted per cycle, results returned in order.

## Timing
- **Clear duration.** Reset is sampled high, then deasserted. The first edge with reset low writes address 0, and the MEM_DEPTH-th such edge writes MEM_DEPTH-1. ready is 1 after that edge, i.e. MEM_DEPTH cycles after reset release.
- **OUT_REG = 0.** rd_en at edge N gives rd_data and rd_valid = 1 after edge N; rd_valid falls after edge N+1 unless another read was issued.
- **OUT_REG = 1.** Same, but the result and rd_valid appear after edge N+1; the valid bit travels with the data stage.
- **Write visibility.** A write at edge N is visible to a read issued at edge N+1.
- **No back-pressure.** There is no stall input; the consumer must accept rd_data when rd_valid = 1.

## Test plan
- **Clear sequence.** Defaults, CLEAR_VALUE = 8'hA5, reset for 2 cycles then release → ready = 0 for exactly 256 cycles, then 1. Reads of addresses 0, 0x7F and 0xFF each return 8'hA5 with rd_valid one cycle after rd_en.
- **Write/read and latency.**
  - Write 8'h3C to 0x10, then read 0x10 the next cycle → rd_data = 8'h3C, rd_valid high for exactly 1 cycle.
  - Repeat with OUT_REG = 1 → result appears one cycle later.
- **Read-during-write.** Location 0x20 holds 8'h11; in one cycle, wr_en with 8'h22 and rd_en, both at 0x20 →
  - RDW_MODE = 0 returns 8'h11.
  - RDW_MODE = 1 returns 8'h22.
  - In both modes, a follow-up read returns 8'h22.
- **Streaming reads.** Write 0x00..0x07 with their address values, then issue rd_en on 8 consecutive cycles with a concurrent write to 0x80 → rd_valid high for 8 consecutive cycles, data 0x00..0x07 in order, and address 0x80 holds the written value.
- **Strobes ignored during clear.** wr_en to 0x05 with 8'hFF and rd_en, both during CLEAR → no rd_valid; after ready, 0x05 reads CLEAR_VALUE.
- **Reset mid-operation.**
  - Assert reset at clear_addr = 100 → ready returns exactly 256 cycles after release.
  - Assert reset in READY with a read in flight → rd_valid does not pulse, and previously written data reads back as CLEAR_VALUE.
